fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter MEM_DEPTH, default 400, giving the number of instruction-memory words; valid PC range is 0..MEM_DEPTH-1.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the word index fetched after reset.
REQ-003 The block SHALL have parameter NOP_WORD, default 32'h00000000, giving the bubble value loaded into the IF/ID instruction register.
Ports (name, direction, width, meaning):
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 stall  input  1  hazard unit request to hold PC and IF/ID.
REQ-007 flush  input  1  request to squash the IF/ID contents.
REQ-008 branch_taken  input  1  redirect request from the execute stage.
REQ-009 branch_target  input  32  word index to redirect to.
REQ-010 instruction  input  32  word returned combinationally by instruction memory for pc.
REQ-011 pc  output  32  word index driven to instruction memory (word-addressed, +1 per instruction).
REQ-012 if_id_instruction  output  32  registered instruction for decode.
REQ-013 if_id_pc  output  32  registered word index of if_id_instruction.
REQ-014 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-015 halted  output  1  fetch is in HALT state.
REQ-016 fetch_count  output  32  number of instructions delivered into IF/ID.

Function
REQ-017 State machine SHALL have two states: RUN (fetching) and HALT (no fetch).
REQ-018 pc SHALL be a register; outputs if_id_* SHALL be registered; pc SHALL never be driven outside 0..MEM_DEPTH-1.
REQ-019 Per-cycle priority SHALL be: rst > branch_taken > flush > stall > normal advance.
REQ-020 Normal advance (RUN, no control input): if_id_instruction<=instruction, if_id_pc<=pc, if_id_valid<=1, pc<=pc+1; latency from pc presented to if_id_* visible = 1 cycle.
REQ-021 Advance with pc==MEM_DEPTH-1: the instruction SHALL be latched as normal, pc SHALL hold at MEM_DEPTH-1, state SHALL go to HALT.
REQ-022 In HALT without branch_taken: pc holds, if_id_instruction<=NOP_WORD, if_id_valid<=0, if_id_pc holds.
REQ-023 branch_taken with branch_target<MEM_DEPTH (any state, regardless of stall/flush): pc<=branch_target, IF/ID loaded with bubble (NOP_WORD, valid 0), state<=RUN.
REQ-024 branch_taken with branch_target>=MEM_DEPTH: pc holds, IF/ID loaded with bubble, state<=HALT.
REQ-025 flush without branch_taken: IF/ID loaded with bubble, pc holds so the current word is refetched next cycle; state unchanged.
REQ-026 stall alone: pc, if_id_* and state SHALL hold their values exactly.
REQ-027 fetch_count SHALL increment by 1 on every edge that loads if_id_valid<=1, saturating at 32'hFFFFFFFF.
REQ-028 halted SHALL be 1 exactly while state is HALT.

Reset
REQ-029 Asserting rst SHALL immediately set pc=RESET_PC, if_id_instruction=NOP_WORD, if_id_pc=0, if_id_valid=0, fetch_count=0, state=RUN, halted=0, also when asserted mid-stall or in HALT.
REQ-030 After rst deasserts, the first rising edge SHALL perform a normal advance from RESET_PC.

Verification
REQ-031 Sequential fetch: memory word k = 32'h1000_0000+k, reset then 3 edges -> if_id_instruction 32'h10000000, 32'h10000001, 32'h10000002; pc=3; fetch_count=3.
REQ-032 Stall: at pc=5 hold stall for 2 edges -> pc stays 5, if_id_pc stays 4, fetch_count unchanged; release -> if_id_pc=5.
REQ-033 Branch over stall: pc=7, stall=1 with branch_taken=1, target=20 -> next edge pc=20, if_id_valid=0; following edge if_id_pc=20, valid=1.
REQ-034 End of memory: run to pc=399 -> edge latches if_id_pc=399, halted=1, pc=399; next edge if_id_valid=0; branch to 0 -> halted=0, pc=0.
REQ-035 Illegal target: branch_taken with target=400 -> halted=1, pc unchanged, if_id_valid=0.
REQ-036 Async reset: assert rst between edges while pc=12 in RUN -> pc=0, if_id_valid=0, fetch_count=0 before the next clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC register, IF/ID register and RUN/HALT control
module fetch_stage #(
    parameter int          MEM_DEPTH = 400,
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_DEPTH);
    localparam logic [31:0] LAST_PC   = 32'(MEM_DEPTH - 1);

    state_t      state, state_nxt;
    logic [31:0] pc_nxt, instr_nxt, ipc_nxt, count_nxt;
    logic        valid_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= RUN;
            pc                <= RESET_PC;
            if_id_instruction <= NOP_WORD;
            if_id_pc          <= 32'd0;
            if_id_valid       <= 1'b0;
            fetch_count       <= 32'd0;
        end else begin
            state             <= state_nxt;
            pc                <= pc_nxt;
            if_id_instruction <= instr_nxt;
            if_id_pc          <= ipc_nxt;
            if_id_valid       <= valid_nxt;
            fetch_count       <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = if_id_instruction;
        ipc_nxt   = if_id_pc;
        valid_nxt = if_id_valid;
        count_nxt = fetch_count;
        if (branch_taken) begin
            instr_nxt = NOP_WORD;
            valid_nxt = 1'b0;
            if (branch_target < MEM_LIMIT) begin
                pc_nxt    = branch_target;
                state_nxt = RUN;
            end else begin
                state_nxt = HALT;
            end
        end else if (flush) begin
            instr_nxt = NOP_WORD;
            valid_nxt = 1'b0;
        end else if (stall) begin
            // everything already defaults to hold
        end else if (state == HALT) begin
            instr_nxt = NOP_WORD;
            valid_nxt = 1'b0;
        end else begin
            instr_nxt = instruction;
            ipc_nxt   = pc;
            valid_nxt = 1'b1;
            if (fetch_count != 32'hFFFFFFFF)
                count_nxt = fetch_count + 32'd1;
            // the last word is delivered, then fetch parks on it
            if (pc == LAST_PC)
                state_nxt = HALT;
            else
                pc_nxt = pc + 32'd1;
        end
    end

    assign halted = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, branch_taken;
    logic [31:0] branch_target, instruction;
    logic [31:0] pc, if_id_instruction, if_id_pc, fetch_count;
    logic        if_id_valid, halted;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] NOP = 32'h00000000;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instruction(instruction), .pc(pc),
        .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign instruction = 32'h1000_0000 + pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                               input logic e_valid, input logic e_halt, input logic [31:0] e_cnt);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".if_id_pc"}, if_id_pc, e_ipc);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halt});
        check({tag, ".count"}, fetch_count, e_cnt);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        #1;
        check_state("reset", 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("reset.instr", if_id_instruction, NOP);
        @(negedge clk);
        rst = 1'b0;

        step();
        check("seq0.instr", if_id_instruction, 32'h10000000);
        check_state("seq0", 32'd1, 32'd0, 1'b1, 1'b0, 32'd1);
        step();
        check("seq1.instr", if_id_instruction, 32'h10000001);
        step();
        check("seq2.instr", if_id_instruction, 32'h10000002);
        check_state("seq2", 32'd3, 32'd2, 1'b1, 1'b0, 32'd3);

        step(); step();
        check_state("prestall", 32'd5, 32'd4, 1'b1, 1'b0, 32'd5);
        stall = 1'b1;
        step();
        check_state("stall1", 32'd5, 32'd4, 1'b1, 1'b0, 32'd5);
        step();
        check_state("stall2", 32'd5, 32'd4, 1'b1, 1'b0, 32'd5);
        check("stall2.instr", if_id_instruction, 32'h10000004);
        stall = 1'b0;
        step();
        check_state("release", 32'd6, 32'd5, 1'b1, 1'b0, 32'd6);

        step();
        check("pre_br.pc", pc, 32'd7);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd20;
        step();
        check_state("br_stall", 32'd20, 32'd6, 1'b0, 1'b0, 32'd7);
        check("br_stall.instr", if_id_instruction, NOP);
        stall = 1'b0; branch_taken = 1'b0;
        step();
        check_state("br_after", 32'd21, 32'd20, 1'b1, 1'b0, 32'd8);
        check("br_after.instr", if_id_instruction, 32'h10000014);

        flush = 1'b1;
        step();
        check_state("flush", 32'd21, 32'd20, 1'b0, 1'b0, 32'd8);
        check("flush.instr", if_id_instruction, NOP);
        flush = 1'b0;
        step();
        check_state("refetch", 32'd22, 32'd21, 1'b1, 1'b0, 32'd9);
        check("refetch.instr", if_id_instruction, 32'h10000015);

        branch_taken = 1'b1; branch_target = 32'd390;
        step();
        branch_taken = 1'b0;
        check("br390.pc", pc, 32'd390);
        repeat (9) step();
        check_state("at399", 32'd399, 32'd398, 1'b1, 1'b0, 32'd18);
        step();
        check_state("end", 32'd399, 32'd399, 1'b1, 1'b1, 32'd19);
        check("end.instr", if_id_instruction, 32'h1000018F);
        step();
        check_state("halt", 32'd399, 32'd399, 1'b0, 1'b1, 32'd19);
        check("halt.instr", if_id_instruction, NOP);
        branch_taken = 1'b1; branch_target = 32'd0;
        step();
        branch_taken = 1'b0;
        check_state("unhalt", 32'd0, 32'd399, 1'b0, 1'b0, 32'd19);

        step();
        check_state("run0", 32'd1, 32'd0, 1'b1, 1'b0, 32'd20);
        branch_taken = 1'b1; branch_target = 32'd400;
        step();
        branch_taken = 1'b0;
        check_state("illegal", 32'd1, 32'd0, 1'b0, 1'b1, 32'd20);

        branch_taken = 1'b1; branch_target = 32'd10;
        step();
        branch_taken = 1'b0;
        step(); step();
        check_state("pre_rst", 32'd12, 32'd11, 1'b1, 1'b0, 32'd22);
        #2 rst = 1'b1;
        #1;
        check_state("async_rst", 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_state("post_rst", 32'd1, 32'd0, 1'b1, 1'b0, 32'd1);
        check("post_rst.instr", if_id_instruction, 32'h10000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
